// File: rtl/cache_controller_2way_param_pkg.sv
// Shared definitions for the 2-way set-associative cache controller:
// FSM state type and address-field width helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FLUSH
    } cache_state_t;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int wsel_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int data_w,
                                 input int line_words, input int sets);
        return addr_w - off_w(data_w) - wsel_w(line_words) - idx_w(sets);
    endfunction

endpackage

// File: rtl/cache_controller_2way_param_if.sv
// CPU-side request bus and SRAM-side line bus of the cache controller.
// master = the environment (CPU + SRAM), slave = the controller.
interface cache_controller_2way_param_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 2
) ();
    logic [ADDR_W-1:0]            address;
    logic [DATA_W-1:0]            wdata;
    logic                         MEM_R_EN;
    logic                         MEM_W_EN;
    logic [DATA_W-1:0]            rdata;
    logic                         ready;
    logic [ADDR_W-1:0]            sram_address;
    logic [DATA_W-1:0]            sram_wdata;
    logic                         sram_write;
    logic                         sram_mem_r_en;
    logic [DATA_W*LINE_WORDS-1:0] sram_rdata;
    logic                         sram_ready;

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_write, sram_mem_r_en
    );

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_write, sram_mem_r_en
    );
endinterface

// File: rtl/cache_controller_2way_param_way_array.sv
// One cache way: per-set valid/tag/line storage with combinational lookup
// and synchronous fill, single-word update and valid-clear ports.
module cache_way_array #(
    parameter int SETS      = 64,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 23,
    parameter int DATA_W    = 32,
    parameter int LINE_W    = 64,
    parameter int WSEL_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx,
    input  logic [TAG_W-1:0]     tag,
    output logic                 hit,
    output logic                 valid,
    output logic [LINE_W-1:0]    line,
    input  logic                 fill_en,
    input  logic [LINE_W-1:0]    fill_line,
    input  logic                 word_en,
    input  logic [WSEL_BITS-1:0] word_sel,
    input  logic [DATA_W-1:0]    word_data,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_idx
);
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    assign valid = valid_q[idx];
    assign line  = line_q[idx];
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);

    always_ff @(posedge clk) begin
        if (!rst)
            valid_q <= '0;
        else if (clr_en)
            valid_q[clr_idx] <= 1'b0;
        else if (fill_en)
            valid_q[idx] <= 1'b1;
    end

    // Tag/line storage carries no reset; valid_q alone decides whether it is live.
    always_ff @(posedge clk) begin
        if (rst && fill_en) begin
            tag_q[idx]  <= tag;
            line_q[idx] <= fill_line;
        end else if (rst && word_en) begin
            line_q[idx][word_sel*DATA_W +: DATA_W] <= word_data;
        end
    end
endmodule

// File: rtl/cache_controller_2way_param.sv
// 2-way set-associative, write-through / no-write-allocate cache controller
// between the MEM stage and the SRAM controller, with LRU, sweep flush and stats.
module cache_controller_2way_param
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 2,
    parameter int SETS       = 64,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    cache_controller_2way_param_if.slave bus,
    input  logic                         flush,
    output logic                         flush_busy,
    output logic [CNT_W-1:0]             hit_count,
    output logic [CNT_W-1:0]             miss_count
);
    localparam int OFF_W      = off_w(DATA_W);
    localparam int WSEL_W     = wsel_w(LINE_WORDS);
    localparam int WSEL_BITS  = (WSEL_W > 0) ? WSEL_W : 1;
    localparam int IDX_W      = idx_w(SETS);
    localparam int TAG_W      = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
    localparam int LINE_W     = DATA_W * LINE_WORDS;
    localparam int LINE_BYTES = LINE_W / 8;

    cache_state_t state, next_state;

    logic [IDX_W-1:0]     flush_idx;
    logic                 flush_pending;
    logic [SETS-1:0]      lru;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_BITS-1:0] wsel;
    logic                 hit0, hit1, valid0, valid1;
    logic [LINE_W-1:0]    line0, line1, hit_line;
    logic                 fill_en, victim, word_en, clr_en;
    logic                 lru_set, lru_val, count_hit, count_miss;

    assign idx  = IDX_W'(bus.address >> (OFF_W + WSEL_W));
    assign tag  = TAG_W'(bus.address >> (OFF_W + WSEL_W + IDX_W));
    assign wsel = WSEL_BITS'((bus.address >> OFF_W) & ADDR_W'(LINE_WORDS - 1));

    assign hit_line   = hit0 ? line0 : line1;
    assign clr_en     = (state == FLUSH);
    assign flush_busy = (state == FLUSH);

    cache_way_array #(
        .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W),
        .DATA_W(DATA_W), .LINE_W(LINE_W), .WSEL_BITS(WSEL_BITS)
    ) u_way0 (
        .clk(clk), .rst(rst), .idx(idx), .tag(tag),
        .hit(hit0), .valid(valid0), .line(line0),
        .fill_en(fill_en && !victim), .fill_line(bus.sram_rdata),
        .word_en(word_en && hit0), .word_sel(wsel), .word_data(bus.wdata),
        .clr_en(clr_en), .clr_idx(flush_idx)
    );

    cache_way_array #(
        .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W),
        .DATA_W(DATA_W), .LINE_W(LINE_W), .WSEL_BITS(WSEL_BITS)
    ) u_way1 (
        .clk(clk), .rst(rst), .idx(idx), .tag(tag),
        .hit(hit1), .valid(valid1), .line(line1),
        .fill_en(fill_en && victim), .fill_line(bus.sram_rdata),
        .word_en(word_en && hit1 && !hit0), .word_sel(wsel), .word_data(bus.wdata),
        .clr_en(clr_en), .clr_idx(flush_idx)
    );

    // Everything is suppressed while rst is low so a completion racing reset has no effect.
    always_comb begin
        next_state        = state;
        bus.ready         = 1'b0;
        bus.rdata         = '0;
        bus.sram_address  = '0;
        bus.sram_wdata    = '0;
        bus.sram_write    = 1'b0;
        bus.sram_mem_r_en = 1'b0;
        fill_en           = 1'b0;
        victim            = 1'b0;
        word_en           = 1'b0;
        lru_set           = 1'b0;
        lru_val           = 1'b0;
        count_hit         = 1'b0;
        count_miss        = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        next_state = FLUSH;
                    end else if (bus.MEM_W_EN) begin
                        next_state = WRITE;
                    end else if (bus.MEM_R_EN) begin
                        if (hit0 || hit1) begin
                            bus.ready = 1'b1;
                            bus.rdata = hit_line[wsel*DATA_W +: DATA_W];
                            lru_set   = 1'b1;
                            lru_val   = hit0;
                            count_hit = 1'b1;
                        end else begin
                            next_state = FILL;
                            count_miss = 1'b1;
                        end
                    end
                end
                FILL: begin
                    bus.sram_mem_r_en = 1'b1;
                    bus.sram_address  = bus.address & ~ADDR_W'(LINE_BYTES - 1);
                    if (bus.sram_ready) begin
                        fill_en    = 1'b1;
                        victim     = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[idx]);
                        lru_set    = 1'b1;
                        lru_val    = ~victim;
                        bus.ready  = 1'b1;
                        bus.rdata  = bus.sram_rdata[wsel*DATA_W +: DATA_W];
                        next_state = (flush_pending || flush) ? FLUSH : IDLE;
                    end
                end
                WRITE: begin
                    bus.sram_write   = 1'b1;
                    bus.sram_address = bus.address;
                    bus.sram_wdata   = bus.wdata;
                    if (bus.sram_ready) begin
                        word_en    = hit0 || hit1;
                        lru_set    = hit0 || hit1;
                        lru_val    = hit0;
                        bus.ready  = 1'b1;
                        next_state = (flush_pending || flush) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_idx == IDX_W'(SETS - 1))
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            flush_idx     <= '0;
            flush_pending <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state         <= next_state;
            flush_idx     <= (state == FLUSH) ? flush_idx + 1'b1 : '0;
            flush_pending <= ((state == FILL) || (state == WRITE)) &&
                             (next_state == state) && (flush_pending || flush);
            if (count_hit && (hit_count != '1))
                hit_count <= hit_count + 1'b1;
            if (count_miss && (miss_count != '1))
                miss_count <= miss_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            lru <= '0;
        else if (state == FLUSH)
            lru[flush_idx] <= 1'b0;
        else if (lru_set)
            lru[idx] <= lru_val;
    end
endmodule

// File: tb/tb_cache_controller_2way_param.sv
// Scoreboard bench for cache_controller_2way_param: a recency-list cache model
// plus a reference memory predict every response; an SRAM responder serves requests.
module tb_cache_controller_2way_param;
    localparam int SETS    = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             flush_busy;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    cache_controller_2way_param_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(2)) bus ();

    cache_controller_2way_param #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(2), .SETS(SETS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .flush(flush),
        .flush_busy(flush_busy),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isWrite;
        bit          expHit;
        logic [31:0] expData;
        int          expFills;
        int          expWrites;
    } exp_t;

    exp_t        scoreboard[$];
    int          checks = 0;
    int          errors = 0;
    int          totalFills = 0;
    int          totalWrites = 0;
    int          sramLatMax = 3;
    int          modelHits = 0;
    int          modelMisses = 0;
    logic [31:0] curAddr = '0;
    logic [31:0] curData = '0;

    // Reference state: backing memory, and per set the resident tags ordered by recency.
    logic [63:0] mem [logic [31:0]];
    int          resident [SETS];
    logic [22:0] mruTag [SETS];
    logic [22:0] lruTag [SETS];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [63:0] lineOf(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:3], 3'b000};
        if (mem.exists(la))
            return mem[la];
        return {la ^ 32'hA5A5_0000, ~la};
    endfunction

    function automatic bit modelAccess(input logic [31:0] a, input bit allocate);
        int          s;
        logic [22:0] t;
        s = int'(a[8:3]);
        t = a[31:9];
        if (resident[s] >= 1 && mruTag[s] == t)
            return 1'b1;
        if (resident[s] == 2 && lruTag[s] == t) begin
            lruTag[s] = mruTag[s];
            mruTag[s] = t;
            return 1'b1;
        end
        if (allocate) begin
            lruTag[s] = mruTag[s];
            mruTag[s] = t;
            if (resident[s] < 2)
                resident[s]++;
        end
        return 1'b0;
    endfunction

    function automatic void modelClear();
        for (int s = 0; s < SETS; s++)
            resident[s] = 0;
    endfunction

    task automatic applyStimulus(input bit isWrite, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic [63:0] ln;
        bit          done;
        e.isWrite = isWrite;
        e.expHit  = modelAccess(a, !isWrite);
        ln        = lineOf(a);
        e.expData = a[2] ? ln[63:32] : ln[31:0];
        if (isWrite) begin
            if (a[2]) ln[63:32] = d;
            else      ln[31:0]  = d;
            mem[{a[31:3], 3'b000}] = ln;
            e.expData = '0;
        end else if (e.expHit) begin
            modelHits = (modelHits < CNT_MAX) ? modelHits + 1 : modelHits;
        end else begin
            modelMisses = (modelMisses < CNT_MAX) ? modelMisses + 1 : modelMisses;
        end
        e.expFills  = totalFills + ((!isWrite && !e.expHit) ? 1 : 0);
        e.expWrites = totalWrites + (isWrite ? 1 : 0);
        scoreboard.push_back(e);
        curAddr      = a;
        curData      = d;
        bus.address  = a;
        bus.wdata    = d;
        bus.MEM_W_EN = isWrite;
        bus.MEM_R_EN = !isWrite || ($urandom_range(0, 1) == 1);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = bus.ready;
        end
        if (!done)
            checkOutput("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        checkOutput("hit_count", 64'(hit_count), 64'(modelHits));
        checkOutput("miss_count", 64'(miss_count), 64'(modelMisses));
    endtask

    task automatic countFlush();
        int n;
        bit started;
        bit ended;
        n = 0;
        started = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 300 && !ended; i++) begin
            @(negedge clk);
            if (flush_busy) begin
                n++;
                started = 1'b1;
            end else if (started) begin
                ended = 1'b1;
            end
        end
        checkOutput("flush_busy_cycles", 64'(n), 64'(SETS));
        modelClear();
    endtask

    task automatic doFlush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        countFlush();
    endtask

    // SRAM responder: checks each request and completes it after a random latency.
    initial begin
        int lat;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && (bus.sram_mem_r_en || bus.sram_write)) begin
                if (bus.sram_mem_r_en) begin
                    checkOutput("sram_rd_addr", 64'(bus.sram_address), 64'({curAddr[31:3], 3'b000}));
                    totalFills++;
                end else begin
                    checkOutput("sram_wr_addr", 64'(bus.sram_address), 64'(curAddr));
                    checkOutput("sram_wdata", 64'(bus.sram_wdata), 64'(curData));
                    totalWrites++;
                end
                lat = $urandom_range(1, sramLatMax);
                repeat (lat) @(posedge clk);
                #1;
                bus.sram_rdata = lineOf(bus.sram_address);
                bus.sram_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.sram_ready = 1'b0;
            end
        end
    end

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ready) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = scoreboard.pop_front();
                    if (!e.isWrite)
                        checkOutput("rdata", 64'(bus.rdata), 64'(e.expData));
                    checkOutput("sram_reads", 64'(totalFills), 64'(e.expFills));
                    checkOutput("sram_writes", 64'(totalWrites), 64'(e.expWrites));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        logic [31:0] a;
        int r;
        bus.address  = '0;
        bus.wdata    = '0;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        modelClear();
        mem[32'h0000_0100] = 64'h2222_2222_1111_1111;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("reset_ready", 64'(bus.ready), 64'd0);
        checkOutput("reset_sram_write", 64'(bus.sram_write), 64'd0);
        checkOutput("reset_sram_rd", 64'(bus.sram_mem_r_en), 64'd0);
        checkOutput("reset_flush_busy", 64'(flush_busy), 64'd0);
        checkOutput("reset_hit_count", 64'(hit_count), 64'd0);
        checkOutput("reset_miss_count", 64'(miss_count), 64'd0);

        applyStimulus(1'b0, 32'h0000_0100, '0);
        applyStimulus(1'b0, 32'h0000_0104, '0);

        // Set 32 conflicts: A=0x100, B=0x300, C=0x500.
        applyStimulus(1'b0, 32'h0000_0100, '0);
        applyStimulus(1'b0, 32'h0000_0300, '0);
        applyStimulus(1'b0, 32'h0000_0100, '0);
        applyStimulus(1'b0, 32'h0000_0500, '0);
        applyStimulus(1'b0, 32'h0000_0100, '0);
        applyStimulus(1'b0, 32'h0000_0300, '0);

        applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0000_0100, '0);
        applyStimulus(1'b1, 32'h0000_0704, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0000_0704, '0);

        // Flush raised while a fill is outstanding.
        fork
            applyStimulus(1'b0, 32'h0000_0900, '0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus.sram_mem_r_en;
                end
                @(posedge clk);
                #1;
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
        join
        checkOutput("flush_after_fill", 64'(flush_busy), 64'd1);
        countFlush();
        applyStimulus(1'b0, 32'h0000_0100, '0);

        // Reset lands in the same cycle as the fill completion.
        sramLatMax   = 1;
        curAddr      = 32'h0000_2000;
        bus.address  = 32'h0000_2000;
        bus.MEM_R_EN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.sram_mem_r_en;
        end
        if (!seen)
            checkOutput("rst_fill_request", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.MEM_R_EN = 1'b0;
        #1;
        checkOutput("rstfill_ready", 64'(bus.ready), 64'd0);
        checkOutput("rstfill_sram_rd", 64'(bus.sram_mem_r_en), 64'd0);
        checkOutput("rstfill_sram_write", 64'(bus.sram_write), 64'd0);
        checkOutput("rstfill_flush_busy", 64'(flush_busy), 64'd0);
        checkOutput("rstfill_hit_count", 64'(hit_count), 64'd0);
        checkOutput("rstfill_miss_count", 64'(miss_count), 64'd0);
        modelClear();
        modelHits   = 0;
        modelMisses = 0;
        sramLatMax  = 3;
        applyStimulus(1'b0, 32'h0000_2000, '0);

        // Random mix over few tags/sets so hits, conflicts and saturation all occur.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 24);
            a = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 3) |
                (32'($urandom_range(0, 1)) << 2);
            if (r == 0)
                doFlush();
            else if (r < 8)
                applyStimulus(1'b1, a, $urandom);
            else
                applyStimulus(1'b0, a, '0);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
